// File: rtl/mont_modexp_ctrl_pkg.sv
// Shared types for the Montgomery modular-exponentiation controller.
package mont_modexp_ctrl_pkg;

    localparam int SIZE_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT,
        ST_SQR,
        ST_MUL,
        ST_FROM_MONT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer that drives one external
// Montgomery multiplier to compute y = base^exponent mod m.
module mont_modexp_ctrl
    import mont_modexp_ctrl_pkg::*;
#(
    parameter int NBITS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_p,
    input  logic [NBITS-1:0]  base,
    input  logic [NBITS-1:0]  r2_mod,
    input  logic [NBITS-1:0]  r_mod,
    input  logic [NBITS-1:0]  exponent,
    input  logic [SIZE_W-1:0] exp_size,
    input  logic [NBITS-1:0]  m,
    input  logic [SIZE_W-1:0] m_size,
    output logic [NBITS-1:0]  y,
    output logic              done_irq_p,
    output logic              busy,
    output logic              mm_enable_p,
    output logic [NBITS-1:0]  mm_a,
    output logic [NBITS-1:0]  mm_b,
    output logic [NBITS-1:0]  mm_m,
    output logic [SIZE_W-1:0] mm_m_size,
    input  logic [NBITS-1:0]  mm_y,
    input  logic              mm_done_irq_p
);

    localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

    state_t            state;
    logic              waiting;
    logic [NBITS-1:0]  exp_q;
    logic [NBITS-1:0]  m_q;
    logic [SIZE_W-1:0] exp_size_q;
    logic [SIZE_W-1:0] m_size_q;
    logic [SIZE_W-1:0] bit_idx;
    logic [NBITS-1:0]  acc;
    logic [NBITS-1:0]  xm;

    logic              cur_bit;
    logic              last_bit;
    state_t            nxt_state;
    logic [NBITS-1:0]  nxt_a;
    logic [NBITS-1:0]  nxt_b;
    logic [SIZE_W-1:0] nxt_idx;

    assign cur_bit   = |(exp_q & (ONE << bit_idx));
    assign last_bit  = (bit_idx == '0);
    assign mm_m      = m_q;
    assign mm_m_size = m_size_q;

    // Next multiplication to issue once the current result (mm_y) arrives.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        nxt_state = ST_DONE;
        nxt_a     = mm_y;
        nxt_b     = mm_y;
        nxt_idx   = bit_idx;
        case (state)
            ST_TO_MONT: begin
                nxt_a = acc;
                if (exp_size_q == '0) begin
                    nxt_state = ST_FROM_MONT;
                    nxt_b     = ONE;
                end else begin
                    nxt_state = ST_SQR;
                    nxt_b     = acc;
                    nxt_idx   = exp_size_q - SIZE_W'(1);
                end
            end
            ST_SQR: begin
                if (cur_bit) begin
                    nxt_state = ST_MUL;
                    nxt_b     = xm;
                end else if (last_bit) begin
                    nxt_state = ST_FROM_MONT;
                    nxt_b     = ONE;
                end else begin
                    nxt_state = ST_SQR;
                    nxt_idx   = bit_idx - SIZE_W'(1);
                end
            end
            ST_MUL: begin
                if (last_bit) begin
                    nxt_state = ST_FROM_MONT;
                    nxt_b     = ONE;
                end else begin
                    nxt_state = ST_SQR;
                    nxt_idx   = bit_idx - SIZE_W'(1);
                end
            end
            default: nxt_state = ST_DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            waiting     <= 1'b0;
            busy        <= 1'b0;
            done_irq_p  <= 1'b0;
            mm_enable_p <= 1'b0;
            mm_a        <= '0;
            mm_b        <= '0;
            y           <= '0;
            exp_q       <= '0;
            m_q         <= '0;
            exp_size_q  <= '0;
            m_size_q    <= '0;
            bit_idx     <= '0;
            acc         <= '0;
            xm          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            mm_enable_p <= 1'b0;
            done_irq_p  <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    // DONE behaves as IDLE so a start on the busy-falling cycle is taken.
                    state <= ST_IDLE;
                    if (enable_p) begin
                        exp_q       <= exponent;
                        exp_size_q  <= exp_size;
                        m_q         <= m;
                        m_size_q    <= m_size;
                        acc         <= r_mod;
                        state       <= ST_TO_MONT;
                        waiting     <= 1'b0;
                        busy        <= 1'b1;
                        mm_enable_p <= 1'b1;
                        mm_a        <= base;
                        mm_b        <= r2_mod;
                    end
                end
                default: begin
                    if (!waiting) begin
                        waiting <= 1'b1;
                    end else if (mm_done_irq_p) begin
                        if (state == ST_TO_MONT) begin
                            xm <= mm_y;
                        end else if (state != ST_FROM_MONT) begin
                            acc <= mm_y;
                        end
                        if (state == ST_FROM_MONT) begin
                            y          <= mm_y;
                            state      <= ST_DONE;
                            done_irq_p <= 1'b1;
                            busy       <= 1'b0;
                            waiting    <= 1'b0;
                        end else begin
                            state       <= nxt_state;
                            waiting     <= 1'b0;
                            mm_enable_p <= 1'b1;
                            mm_a        <= nxt_a;
                            mm_b        <= nxt_b;
                            bit_idx     <= nxt_idx;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Self-checking bench: behavioural variable-latency Montgomery multiplier plus
// a plain-arithmetic modular exponentiation reference.
module tb_mont_modexp_ctrl;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_p = 1'b0;
    logic [NB-1:0] base = '0;
    logic [NB-1:0] r2_mod = '0;
    logic [NB-1:0] r_mod = '0;
    logic [NB-1:0] exponent = '0;
    logic [11:0]   exp_size = '0;
    logic [NB-1:0] m = '0;
    logic [11:0]   m_size = '0;
    logic [NB-1:0] y;
    logic          done_irq_p;
    logic          busy;
    logic          mm_enable_p;
    logic [NB-1:0] mm_a;
    logic [NB-1:0] mm_b;
    logic [NB-1:0] mm_m;
    logic [11:0]   mm_m_size;
    logic [NB-1:0] mm_y = '0;
    logic          mm_done_irq_p;
    logic          model_done = 1'b0;
    logic          spur_done = 1'b0;

    assign mm_done_irq_p = model_done | spur_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_ops = 0;
    int n_done = 0;
    int rst_count = 0;

    mont_modexp_ctrl #(.NBITS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .enable_p(enable_p), .base(base),
        .r2_mod(r2_mod), .r_mod(r_mod), .exponent(exponent), .exp_size(exp_size),
        .m(m), .m_size(m_size), .y(y), .done_irq_p(done_irq_p), .busy(busy),
        .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_m_size(mm_m_size), .mm_y(mm_y), .mm_done_irq_p(mm_done_irq_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // a * b * R^-1 mod mm with R = 2^k, by brute-force inverse of R.
    function automatic logic [NB-1:0] mont_mul(input int unsigned a, input int unsigned b,
                                               input int unsigned mm, input int unsigned k);
        longint unsigned r, inv, p;
        r   = (64'd1 << k) % mm;
        inv = 0;
        for (longint unsigned i = 1; i < mm; i++)
            if ((r * i) % mm == 1) inv = i;
        p = ((longint'(a) * longint'(b)) % mm) * inv % mm;
        return p[NB-1:0];
    endfunction

    function automatic int unsigned masked_exp(input int unsigned e, input int unsigned es);
        return e & ((32'd1 << es) - 32'd1);
    endfunction

    function automatic int unsigned ref_pow(input int unsigned x, input int unsigned e,
                                            input int unsigned es, input int unsigned mm);
        longint unsigned r;
        r = 1 % mm;
        for (int unsigned i = 0; i < masked_exp(e, es); i++) r = (r * x) % mm;
        return 32'(r);
    endfunction

    always @(negedge rst_n) rst_count++;

    always @(negedge clk) begin
        if (mm_enable_p) n_ops++;
        if (done_irq_p)  n_done++;
    end

    initial begin : mm_model
        logic [NB-1:0] ca, cb, cm;
        logic [11:0]   cs;
        int            rc;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (mm_enable_p) begin
                ca = mm_a; cb = mm_b; cm = mm_m; cs = mm_m_size; rc = rst_count;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                if (rc == rst_count) begin
                    check("mm_a_stable", mm_a, ca);
                    check("mm_b_stable", mm_b, cb);
                end
                mm_y = mont_mul(ca, cb, cm, cs);
                model_done = 1'b1;
            end
        end
    end

    task automatic set_inputs(input int unsigned x, input int unsigned e, input int unsigned es,
                              input int unsigned mm, input int unsigned k);
        longint unsigned r1, r2;
        r1 = (64'd1 << k) % mm;
        r2 = (64'd1 << (2 * k)) % mm;
        base     = x[NB-1:0];
        exponent = e[NB-1:0];
        exp_size = es[11:0];
        m        = mm[NB-1:0];
        m_size   = k[11:0];
        r_mod    = r1[NB-1:0];
        r2_mod   = r2[NB-1:0];
    endtask

    task automatic drive_start(input int unsigned x, input int unsigned e, input int unsigned es,
                               input int unsigned mm, input int unsigned k);
        @(negedge clk);
        set_inputs(x, e, es, mm, k);
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done_irq_p) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_run(input string tag, input int unsigned x, input int unsigned e,
                          input int unsigned es, input int unsigned mm, input int unsigned k);
        int ops0, done0;
        bit got;
        ops0 = n_ops; done0 = n_done;
        drive_start(x, e, es, mm, k);
        check({tag, "_busy"}, busy, 1);
        wait_done(got);
        check({tag, "_finished"}, got, 1);
        check({tag, "_y_at_done"}, y, ref_pow(x, e, es, mm));
        repeat (8) @(negedge clk);
        check({tag, "_y_hold"}, y, ref_pow(x, e, es, mm));
        check({tag, "_ops"}, n_ops - ops0, 2 + es + $countones(masked_exp(e, es)));
        check({tag, "_done_cnt"}, n_done - done0, 1);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int  ops0, done0, seen;
        bit  got;
        int unsigned mm, x, e, es;

        repeat (3) @(negedge clk);
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_irq_p, 0);
        check("rst_mm_en", mm_enable_p, 0);
        check("rst_mm_m", mm_m, 0);
        check("rst_mm_m_size", mm_m_size, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_run("basic", 2, 5, 3, 13, 4);
        do_run("esz0", 2, 5, 0, 13, 4);
        do_run("upper_ign", 7, 'hF0, 4, 13, 4);

        // Stray multiplier completions while idle.
        ops0 = n_ops; done0 = n_done;
        repeat (3) begin
            @(negedge clk); spur_done = 1'b1;
            @(negedge clk); spur_done = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("idle_done_y", y, 1);
        check("idle_done_busy", busy, 0);
        check("idle_done_ops", n_ops - ops0, 0);
        check("idle_done_cnt", n_done - done0, 0);

        // Starts while busy, with different operands on the inputs.
        ops0 = n_ops; done0 = n_done;
        drive_start(2, 5, 3, 13, 4);
        repeat (3) @(negedge clk);
        set_inputs(9, 'hFF, 8, 13, 4);
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        repeat (6) @(negedge clk);
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        wait_done(got);
        check("busy_start_finished", got, 1);
        repeat (8) @(negedge clk);
        check("busy_start_y", y, 6);
        check("busy_start_ops", n_ops - ops0, 7);
        check("busy_start_done", n_done - done0, 1);

        // Reset while waiting on the first square.
        done0 = n_done;
        drive_start(2, 5, 3, 13, 4);
        seen = 1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mm_enable_p) seen++;
            if (seen == 2) begin
                got = 1'b1;
                break;
            end
        end
        check("abort_reached_sqr", got, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_y", y, 0);
        check("abort_mm_en", mm_enable_p, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", n_done - done0, 0);
        check("abort_y_after", y, 0);
        do_run("after_abort", 2, 5, 3, 13, 4);

        // Back-to-back: second start on the cycle busy falls.
        ops0 = n_ops; done0 = n_done;
        drive_start(3, 6, 3, 13, 4);
        wait_done(got);
        check("b2b_first_finished", got, 1);
        check("b2b_first_y", y, ref_pow(3, 6, 3, 13));
        check("b2b_first_busy", busy, 0);
        set_inputs(2, 5, 3, 13, 4);
        enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        check("b2b_second_busy", busy, 1);
        wait_done(got);
        check("b2b_second_finished", got, 1);
        check("b2b_second_y", y, 6);
        repeat (8) @(negedge clk);
        check("b2b_ops", n_ops - ops0, 14);
        check("b2b_done_cnt", n_done - done0, 2);

        for (int i = 0; i < 20; i++) begin
            mm = $urandom_range(1, 127) * 2 + 1;
            x  = $urandom_range(0, mm - 1);
            e  = $urandom_range(0, 255);
            es = $urandom_range(0, 8);
            do_run($sformatf("rnd%0d", i), x, e, es, mm, 8);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
